// File: rtl/clint.sv
// clint: core-local interrupt/exception controller.
// Sits beside the execute stage. It detects ecall, ebreak, mret and enabled
// external interrupts, stalls the pipeline, and writes the trap CSRs through
// the CSR file's clint write port. It then redirects fetch for one cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   int_flag_i[7:0]     level external interrupt lines (any bit set = request)
//   inst_i, inst_addr_i instruction in execute and its address
//   jump_flag_i/addr_i  execute is taking a jump this cycle, and its target
//   hold_flag_i         pipeline already held by another unit
//   csr_mtvec_i, csr_mepc_i, csr_mstatus_i  current CSR values
//   we_o/waddr_o/wdata_o  registered CSR write port (we_o = 0 in IDLE)
//   hold_flag_o         combinational stall request
//   int_assert_o        one-cycle redirect strobe
//   int_addr_o          redirect target; holds until the next strobe
//
// Handshake: the controller has no ready input. hold_flag_o rises in the
// cycle a request is accepted and stays high through every W_* state, so
// execute never writes CSRs while the clint port is busy. int_assert_o is a
// single-cycle strobe with int_addr_o valid in the same cycle, and
// hold_flag_o is low in that cycle.
module clint #(
  parameter logic [31:0] CAUSE_ECALL   = 32'h0000000B,
  parameter logic [31:0] CAUSE_EBREAK  = 32'h00000003,
  parameter logic [31:0] CAUSE_EXT_INT = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h00000073;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;
  localparam logic [31:0] INST_MRET   = 32'h30200073;

  localparam logic [31:0] ADDR_MSTATUS = 32'h00000300;
  localparam logic [31:0] ADDR_MEPC    = 32'h00000341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h00000342;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_W_MRET
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;

  logic        is_ecall, is_ebreak, is_sync, is_mret, is_async, req_any;
  logic [31:0] trap_mstatus, mret_mstatus, async_epc;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_sync   = is_ecall | is_ebreak;
  assign is_mret   = (inst_i == INST_MRET);
  assign is_async  = (int_flag_i != 8'h00) & csr_mstatus_i[3] & ~hold_flag_i;
  assign req_any   = (state_q == S_IDLE) & (is_sync | is_mret | is_async);

  // The interrupted instruction has not executed yet; if ex is redirecting,
  // the jump target is the first instruction that still has to run.
  assign async_epc = jump_flag_i ? jump_addr_i : inst_addr_i;

  // Trap entry: MPIE <= MIE, MIE <= 0. Trap return: MIE <= MPIE, MPIE <= 1.
  assign trap_mstatus = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                         csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
  assign mret_mstatus = {csr_mstatus_i[31:8], 1'b1,
                         csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};

  // The write for a state is computed on entry to that state, so it is
  // visible from the register during the cycle the state is occupied.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    we_d         = 1'b0;
    waddr_d      = 32'h0;
    wdata_d      = 32'h0;
    int_assert_d = 1'b0;
    int_addr_d   = int_addr_q;
    case (state_q)
      S_IDLE: begin
        if (is_sync) begin
          epc_d   = inst_addr_i;
          cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          state_d = S_W_MEPC;
          we_d    = 1'b1;
          waddr_d = ADDR_MEPC;
          wdata_d = inst_addr_i;
        end else if (is_mret) begin
          state_d = S_W_MRET;
          we_d    = 1'b1;
          waddr_d = ADDR_MSTATUS;
          wdata_d = mret_mstatus;
        end else if (is_async) begin
          epc_d   = async_epc;
          cause_d = CAUSE_EXT_INT;
          state_d = S_W_MEPC;
          we_d    = 1'b1;
          waddr_d = ADDR_MEPC;
          wdata_d = async_epc;
        end
      end
      S_W_MEPC: begin
        state_d = S_W_MSTATUS;
        we_d    = 1'b1;
        waddr_d = ADDR_MSTATUS;
        wdata_d = trap_mstatus;
      end
      S_W_MSTATUS: begin
        state_d = S_W_MCAUSE;
        we_d    = 1'b1;
        waddr_d = ADDR_MCAUSE;
        wdata_d = cause_q;
      end
      S_W_MCAUSE: begin
        state_d      = S_IDLE;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mtvec_i;
      end
      S_W_MRET: begin
        state_d      = S_IDLE;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc_i;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epc_q        <= 32'h0;
      cause_q      <= 32'h0;
      we_q         <= 1'b0;
      waddr_q      <= 32'h0;
      wdata_q      <= 32'h0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;
  assign hold_flag_o  = (state_q != S_IDLE) | req_any;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: CSR writes and redirects are checked against
// expected queues filled when each request is driven.
module tb_clint;

  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] MRET   = 32'h30200073;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, hold_flag_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, wdata_o, int_addr_o;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];   // {waddr, wdata} per expected CSR write
  logic [31:0] exp_r_q[$]; // expected redirect targets

  clint dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .int_flag_i    (int_flag_i),
    .inst_i        (inst_i),
    .inst_addr_i   (inst_addr_i),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .csr_mtvec_i   (csr_mtvec_i),
    .csr_mepc_i    (csr_mepc_i),
    .csr_mstatus_i (csr_mstatus_i),
    .we_o          (we_o),
    .waddr_o       (waddr_o),
    .wdata_o       (wdata_o),
    .hold_flag_o   (hold_flag_o),
    .int_assert_o  (int_assert_o),
    .int_addr_o    (int_addr_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to the next falling edge and score any write/redirect seen.
  task automatic cyc();
    logic [63:0] e;
    logic [31:0] r;
    @(negedge clk);
    if (we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $error("FAIL unexpected_write: observed=%0h/%0h expected none", waddr_o, wdata_o);
      end else begin
        e = exp_q.pop_front();
        chk("csr_write", {waddr_o, wdata_o}, e);
      end
    end
    if (int_assert_o === 1'b1) begin
      if (exp_r_q.size() == 0) begin
        total++; bad++;
        $error("FAIL unexpected_redirect: observed=%0h expected none", int_addr_o);
      end else begin
        r = exp_r_q.pop_front();
        chk("redirect_addr", {32'h0, int_addr_o}, {32'h0, r});
      end
    end
  endtask

  task automatic clear_req();
    inst_i      = NOP;
    int_flag_i  = 8'h00;
    jump_flag_i = 1'b0;
  endtask

  task automatic push_trap(input logic [31:0] epc, input logic [31:0] mst,
                           input logic [31:0] cause, input logic [31:0] mtvec);
    exp_q.push_back({32'h341, epc});
    exp_q.push_back({32'h300, mst});
    exp_q.push_back({32'h342, cause});
    exp_r_q.push_back(mtvec);
  endtask

  // Runs from the cycle a request is accepted until the redirect strobe.
  task automatic run_seq(input int lat);
    int got;
    got = 0;
    for (int k = 1; k <= lat + 4; k++) begin
      cyc();
      if (k == 1) clear_req();
      if (int_assert_o === 1'b1) begin
        got = k;
        chk("hold_at_redirect", {63'h0, hold_flag_o}, 64'h0);
        break;
      end else begin
        chk("hold_during_seq", {63'h0, hold_flag_o}, 64'h1);
      end
    end
    chk("redirect_latency", 64'(got), 64'(lat));
  endtask

  initial begin
    rst_n         = 1'b0;
    int_flag_i    = 8'h00;
    inst_i        = NOP;
    inst_addr_i   = 32'h0;
    jump_flag_i   = 1'b0;
    jump_addr_i   = 32'h0;
    hold_flag_i   = 1'b0;
    csr_mtvec_i   = 32'h80;
    csr_mepc_i    = 32'h0;
    csr_mstatus_i = 32'h8;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_we", {63'h0, we_o}, 64'h0);
    chk("rst_waddr", {32'h0, waddr_o}, 64'h0);
    chk("rst_wdata", {32'h0, wdata_o}, 64'h0);
    chk("rst_int_assert", {63'h0, int_assert_o}, 64'h0);
    chk("rst_int_addr", {32'h0, int_addr_o}, 64'h0);
    chk("rst_hold", {63'h0, hold_flag_o}, 64'h0);
    rst_n = 1'b1;
    cyc();

    // ecall
    inst_i = ECALL; inst_addr_i = 32'h100;
    push_trap(32'h100, 32'h80, 32'hB, 32'h80);
    #1 chk("hold_on_accept", {63'h0, hold_flag_o}, 64'h1);
    run_seq(4);
    cyc();

    // ebreak
    inst_i = EBREAK; inst_addr_i = 32'h200;
    push_trap(32'h200, 32'h80, 32'h3, 32'h80);
    #1 chk("hold_on_accept", {63'h0, hold_flag_o}, 64'h1);
    run_seq(4);
    cyc();

    // mret: only an mstatus write, then redirect to mepc
    inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    exp_q.push_back({32'h300, 32'h88});
    exp_r_q.push_back(32'h104);
    #1 chk("hold_on_accept", {63'h0, hold_flag_o}, 64'h1);
    run_seq(2);
    cyc();

    // Interrupt pending with MIE = 0 is never taken
    int_flag_i = 8'h01; csr_mstatus_i = 32'h0; inst_addr_i = 32'h1F0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("mie_off_hold", {63'h0, hold_flag_o}, 64'h0);
    end
    // Enabled but another unit holds the pipeline
    csr_mstatus_i = 32'h8; hold_flag_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("held_no_int", {63'h0, hold_flag_o}, 64'h0);
    end
    // Release: interrupt taken, epc is inst_addr
    csr_mtvec_i = 32'h90;
    push_trap(32'h1F0, 32'h80, 32'h8000000B, 32'h90);
    hold_flag_i = 1'b0;
    #1 chk("hold_on_accept", {63'h0, hold_flag_o}, 64'h1);
    run_seq(4);
    cyc();

    // Interrupt during a jump: epc is the jump target
    int_flag_i = 8'h40; jump_flag_i = 1'b1; jump_addr_i = 32'h300; inst_addr_i = 32'h1F0;
    push_trap(32'h300, 32'h80, 32'h8000000B, 32'h90);
    #1 chk("hold_on_accept", {63'h0, hold_flag_o}, 64'h1);
    run_seq(4);
    cyc();

    // ecall and interrupt together: ecall wins
    inst_i = ECALL; inst_addr_i = 32'h400; int_flag_i = 8'h02;
    push_trap(32'h400, 32'h80, 32'hB, 32'h90);
    run_seq(4);
    cyc();

    // Reset while in W_MSTATUS
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mtvec_i = 32'h80;
    exp_q.push_back({32'h341, 32'h100});
    exp_q.push_back({32'h300, 32'h80});
    cyc();
    clear_req();
    cyc();
    chk("in_w_mstatus", {32'h0, waddr_o}, 64'h300);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", {63'h0, we_o}, 64'h0);
    chk("mid_rst_waddr", {32'h0, waddr_o}, 64'h0);
    chk("mid_rst_wdata", {32'h0, wdata_o}, 64'h0);
    chk("mid_rst_int_assert", {63'h0, int_assert_o}, 64'h0);
    chk("mid_rst_int_addr", {32'h0, int_addr_o}, 64'h0);
    chk("mid_rst_hold", {63'h0, hold_flag_o}, 64'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("post_rst_idle_hold", {63'h0, hold_flag_o}, 64'h0);
    end

    // Fresh ecall after the aborted sequence
    inst_i = ECALL; inst_addr_i = 32'h500;
    push_trap(32'h500, 32'h80, 32'hB, 32'h80);
    run_seq(4);
    repeat (3) cyc();

    chk("writes_left", 64'(exp_q.size()), 64'h0);
    chk("redirects_left", 64'(exp_r_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
